rsa_result_demux: RTL

- Steers each 6-bit result from the RSA iteration core to one of two destinations: the feedback path (R input of the operand select mux) or the final result port.
- Counts iterations per operation and drives the operand mux select: D on the first iteration, R afterwards.
- Sits between the modular-multiply datapath output and both the operand select mux and the result consumer.
- Valid/ready handshake on every channel; each output channel has a registered single-entry buffer.

---
 rtl/rsa_result_demux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rsa_result_demux.sv
// Result steering for the RSA iteration core: beats 1..N-1 go to the feedback path and beat N goes to the result port.
// Optional macro RSA_RESULT_DEMUX_PARITY_EN adds out_par, the even parity of out_data.
module rsa_result_demux #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] iter_count,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] fb_data,
    output logic             fb_valid,
    input  logic             fb_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy,
`ifdef RSA_RESULT_DEMUX_PARITY_EN
    output logic             out_par,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_fbData;
    logic             r_fbValid;
    logic [WIDTH-1:0] r_outData;
    logic             r_outValid;
    logic             r_sel;
`ifdef RSA_RESULT_DEMUX_PARITY_EN
    logic             r_outPar;
`endif

    logic w_last;
    logic w_inReady;
    logic w_accept;
    logic w_fbLoad;
    logic w_outLoad;
    logic w_fbDrain;
    logic w_outDrain;
    logic w_busy;
    logic w_done;

    assign w_last     = (r_rem == ONE);
    assign w_fbDrain  = r_fbValid & fb_ready;
    assign w_outDrain = r_outValid & out_ready;

    // in_ready is a function of state, counter, buffer occupancy and the consumers' ready only.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_accept    = 1'b0;
        w_fbLoad    = 1'b0;
        w_outLoad   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_nextState = ROUTE;
            end
            ROUTE: begin
                w_busy    = 1'b1;
                w_inReady = w_last ? ~r_outValid : (~r_fbValid | fb_ready);
                w_accept  = in_valid & w_inReady;
                w_fbLoad  = w_accept & ~w_last;
                w_outLoad = w_accept & w_last;
                if (w_outLoad) w_nextState = FINAL;
            end
            FINAL: begin
                w_busy = 1'b1;
                if (w_outDrain) begin
                    w_done      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && start) begin
                r_rem <= (iter_count == '0) ? ONE : iter_count;
            end else if (w_accept) begin
                r_rem <= r_rem - ONE;
            end
            if (w_fbLoad) begin
                r_sel <= 1'b1;
            end else if (r_state == FINAL && w_outDrain) begin
                r_sel <= 1'b0;
            end
        end
    end

    // Fill takes priority over drain so a same-cycle drain and fill keeps fb_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fbData   <= '0;
            r_fbValid  <= 1'b0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            if (w_fbLoad) begin
                r_fbData  <= in_data;
                r_fbValid <= 1'b1;
            end else if (w_fbDrain) begin
                r_fbValid <= 1'b0;
            end
            if (w_outLoad) begin
                r_outData  <= in_data;
                r_outValid <= 1'b1;
            end else if (w_outDrain) begin
                r_outValid <= 1'b0;
            end
        end
    end

`ifdef RSA_RESULT_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outPar <= 1'b0;
        end else if (w_outLoad) begin
            r_outPar <= ^in_data;
        end
    end

    assign out_par = r_outPar;
`endif

    assign in_ready  = w_inReady;
    assign fb_data   = r_fbData;
    assign fb_valid  = r_fbValid;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign sel       = r_sel;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule
